banked_ram: RTL and testbench
=============================

// Module: banked_ram
// PURPOSE
// - Parametrised single-port RAM built from BANKS block-RAM banks of BANK_DEPTH words each.
//   Bank select is the upper address bits; no subtraction is used.
// - After reset, a built-in init engine zero-fills every bank. Reads are fully pipelined,
//   with fixed latency and a valid flag.
// - Sits between a request master (CPU/DMA/test FSM) and on-chip BRAM, as the general
//   replacement for fixed 4x1024x4 memories.
// PARAMETERS
// - DATA_W      4     data word width in bits (>=1)
// - BANK_DEPTH  1024  words per bank; power of 2, >=2
// - BANKS       4     number of banks; power of 2, >=1
// - AW          $clog2(BANKS*BANK_DEPTH)  derived local parameter; not overridable
// PORTS
// - clk        in   1       rising-edge clock
// - rst        in   1       synchronous reset, active-high
// - req_valid  in   1       request present this cycle
// - req_ready  out  1       block accepts a request; transfer = req_valid & req_ready
// - req_we     in   1       1 = write, 0 = read
// - req_addr   in   AW      bank = req_addr[AW-1 -: $clog2(BANKS)], word = low bits
// - req_wdata  in   DATA_W  write data
// - par_inject in   1       on an accepted write, store inverted parity (test hook)
// - rd_valid   out  1       one-cycle pulse; rd_data/rd_perr valid this cycle
// - rd_data    out  DATA_W  read data; holds its value between pulses
// - rd_perr    out  1       parity mismatch on this read (qualified by rd_valid)
// - init_busy  out  1       init engine is zero-filling the banks
// BEHAVIOUR
// - Reset (rst=1 at an edge): state<=INIT, init_cnt<=0, req_ready<=0, rd_valid<=0,
//   rd_data<=0, rd_perr<=0, init_busy<=1, read pipeline flushed.
// - FSM has two states: INIT and RUN.
//   - INIT: each cycle writes 0 (with correct parity) at word init_cnt of ALL banks,
//     then init_cnt++. After the word BANK_DEPTH-1 write, go to RUN.
//     INIT lasts exactly BANK_DEPTH cycles after rst falls.
//   - RUN: req_ready=1 every cycle, init_busy=0. There is no way back to INIT except rst.
// - req_ready is a registered output, 0 in INIT and 1 in RUN. Requests with req_ready=0
//   are ignored; the master holds them.
// - Write: only the selected bank's write enable asserts; other banks are untouched.
//   No rd_valid is produced.
// - Read latency is exactly 2 cycles from the accepted edge to rd_valid=1.
//   - Stage 1: bank BRAM registered output; bank index and valid are delayed in parallel.
//   - Stage 2: output mux register driven by the delayed bank index.
// - Throughput is 1 request/cycle; reads may be back-to-back to any mix of banks.
// - BRAM mode is read-first. A write at N then a read of the same address at N+1 returns
//   the new data. A read and a write cannot coincide (single port).
// - The address space is exact (BANKS*BANK_DEPTH = 2**AW), so there are no out-of-range
//   addresses. The address wraps only at the master.
// - rst during in-flight reads: pending rd_valid pulses are dropped, and all banks are
//   re-zeroed by INIT.
// - BANKS=1: the bank field is empty and the mux degenerates, but latency stays 2.
// CONFIGURATION
// - BANKED_RAM_PARITY_EN defined:
//   - Each bank stores DATA_W+1 bits, the extra bit being even parity ^(wdata) ^ par_inject.
//   - Stage 2 recomputes parity and sets rd_perr=1 with rd_valid on mismatch.
//   - rd_data is still returned unmodified.
// - BANKED_RAM_PARITY_EN undefined:
//   - Banks are DATA_W wide, rd_perr is tied 0, and par_inject is ignored.
//   - Ports are identical in both builds.
// TESTING (defaults DATA_W=4, BANK_DEPTH=1024, BANKS=4, AW=12)
// - Reset/init: rst 1 cycle, then idle -> init_busy=1 and req_ready=0 for 1024 cycles,
//   then req_ready=1. Reads of 0x000, 0x3FF, 0x400, 0xFFF all return 0x0.
// - Bank decode: write 0xA@0x3FF, 0xB@0x400, 0xC@0x800, 0xD@0xC00, then read each ->
//   0xA,0xB,0xC,0xD, each exactly 2 cycles after acceptance. Neighbours 0x3FE/0x401 stay 0.
// - Pipelining: back-to-back reads 0x400,0xC00,0x3FF on 3 consecutive cycles ->
//   rd_valid high 3 consecutive cycles with data 0xB,0xD,0xA.
// - Write-then-read: write 0x5@0x123 at cycle N, read 0x123 at N+1 -> rd_data=0x5 at N+3.
//   No rd_valid at N+2.
// - Reset mid-run: issue reads at N and N+1, rst=1 at N+1 -> no rd_valid afterwards.
//   After the 1024-cycle re-init, 0x3FF reads 0x0.
// - Parity (macro on): write 0x7@0x010 with par_inject=1, read -> rd_data=0x7, rd_perr=1.
//   Rewrite with par_inject=0, read -> rd_perr=0. With macro off, rd_perr is always 0.

Source files
------------

// File: rtl/banked_ram.sv
// banked_ram: single-port RAM of BANKS x BANK_DEPTH words, zero-filled by an init engine
// after reset, with a 2-cycle pipelined read. Optional parity storage: BANKED_RAM_PARITY_EN.
module banked_ram #(
  parameter int DATA_W     = 4,
  parameter int BANK_DEPTH = 1024,
  parameter int BANKS      = 4,
  localparam int AW        = $clog2(BANKS * BANK_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              par_inject,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_perr,
  output logic              init_busy
);

  localparam int WW  = $clog2(BANK_DEPTH);
  localparam int BW  = $clog2(BANKS);
  localparam int BSW = (BW > 0) ? BW : 1;
`ifdef BANKED_RAM_PARITY_EN
  localparam int MW  = DATA_W + 1;
`else
  localparam int MW  = DATA_W;
`endif

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic par_f(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t                   state_r, state_next_s;
  logic [WW-1:0]            init_cnt_r;
  logic                     init_we_s;
  logic                     req_ready_r, init_busy_r;
  logic                     req_fire_s, wr_fire_s, rd_fire_s;
  logic [BSW-1:0]           bank_s;
  logic [WW-1:0]            word_s;
  logic [WW-1:0]            mem_addr_s;
  logic [MW-1:0]            mem_wdata_s;
  logic [BANKS-1:0]         bank_we_s;
  logic [BANKS-1:0][MW-1:0] dout_s;
  logic                     rd_v1_r;
  logic [BSW-1:0]           bank_d1_r;
  logic [MW-1:0]            sel_s;
  logic                     rd_valid_r;
  logic [DATA_W-1:0]        rd_data_r;
  logic                     rd_perr_r;

  // Bank field is absent with a single bank; it then always selects bank 0.
  if (BANKS > 1) begin : g_sel
    assign bank_s = req_addr[AW-1 -: BW];
  end else begin : g_nosel
    assign bank_s = 1'b0;
  end
  assign word_s = req_addr[WW-1:0];

  // Next-state logic: INIT walks every word once, then RUN forever until reset.
  always_comb begin
    state_next_s = state_r;
    init_we_s    = 1'b0;
    case (state_r)
      ST_INIT: begin
        init_we_s = 1'b1;
        if (init_cnt_r == WW'(BANK_DEPTH - 1)) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_INIT;
    endcase
  end

  // State register, init counter and the registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= '0;
      req_ready_r <= 1'b0;
      init_busy_r <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      init_cnt_r  <= init_we_s ? init_cnt_r + WW'(1) : init_cnt_r;
      req_ready_r <= (state_next_s == ST_RUN);
      init_busy_r <= (state_next_s == ST_INIT);
    end
  end

  assign req_fire_s = req_valid & req_ready_r & ~rst;
  assign wr_fire_s  = req_fire_s & req_we;
  assign rd_fire_s  = req_fire_s & ~req_we;

  // Shared port address/data: init engine owns the port while INIT is active.
  always_comb begin
    mem_addr_s  = word_s;
    mem_wdata_s = '0;
    bank_we_s   = '0;
    if (init_we_s && !rst) begin
      mem_addr_s  = init_cnt_r;
      mem_wdata_s = '0;
      bank_we_s   = '1;
    end else begin
      mem_addr_s  = word_s;
`ifdef BANKED_RAM_PARITY_EN
      mem_wdata_s = {par_f(req_wdata) ^ par_inject, req_wdata};
`else
      mem_wdata_s = req_wdata;
`endif
      for (int i = 0; i < BANKS; i++) begin
        bank_we_s[i] = wr_fire_s & (bank_s == BSW'(i));
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [MW-1:0] mem_r [BANK_DEPTH];
    logic [MW-1:0] dout_r;

    // Read-first BRAM: registered output returns the pre-write contents.
    always_ff @(posedge clk) begin
      if (bank_we_s[b]) begin
        mem_r[mem_addr_s] <= mem_wdata_s;
      end
      dout_r <= mem_r[mem_addr_s];
    end

    assign dout_s[b] = dout_r;
  end

  // Stage 1 side-band: valid and bank index travel alongside the BRAM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1_r   <= 1'b0;
      bank_d1_r <= '0;
    end else begin
      rd_v1_r   <= rd_fire_s;
      bank_d1_r <= bank_s;
    end
  end

  assign sel_s = dout_s[bank_d1_r];

  // Stage 2: output mux register; data holds between read pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      rd_perr_r  <= 1'b0;
    end else begin
      rd_valid_r <= rd_v1_r;
      if (rd_v1_r) begin
        rd_data_r <= sel_s[DATA_W-1:0];
`ifdef BANKED_RAM_PARITY_EN
        rd_perr_r <= par_f(sel_s[DATA_W-1:0]) ^ sel_s[DATA_W];
`else
        rd_perr_r <= 1'b0;
`endif
      end
    end
  end

`ifndef BANKED_RAM_PARITY_EN
  logic unused_par_s;
  assign unused_par_s = par_inject;
`endif

  assign req_ready = req_ready_r;
  assign init_busy = init_busy_r;
  assign rd_valid  = rd_valid_r;
  assign rd_data   = rd_data_r;
  assign rd_perr   = rd_perr_r;

endmodule

// File: tb/tb_banked_ram.sv
// tb_banked_ram: vector table plus read scoreboard for banked_ram at default parameters;
// expected reads carry the cycle at which their rd_valid pulse must appear.
module tb_banked_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = 12'h000;
  logic [3:0]  req_wdata = 4'h0;
  logic        par_inject = 1'b0;
  logic        rd_valid;
  logic [3:0]  rd_data;
  logic        rd_perr;
  logic        init_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rv_cnt = 0;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [3:0]  wdata;
    logic        inj;
    logic [3:0]  exp_data;
    logic        exp_perr;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [3:0] data;
    logic       perr;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[$];

  banked_ram dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .par_inject(par_inject), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_perr(rd_perr), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every pulse must match the head entry and its due cycle.
  always @(negedge clk) begin
    if (rd_valid) begin
      rv_cnt++;
      if (sb_q.size() == 0) begin
        chk("rd_valid_unexpected", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("rd_latency", cyc, e.cyc);
        chk("rd_data", rd_data, e.data);
        chk("rd_perr", rd_perr, e.perr);
      end
    end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      chk("rd_valid_missing", 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end
  end

  task automatic issue(input vec_t v);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    par_inject = v.inj;
    chk("req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    if (!v.we) sb_q.push_back('{cyc + 1, v.exp_data, v.exp_perr});
  endtask

  task automatic idle(input int n);
    req_valid  = 1'b0;
    req_we     = 1'b0;
    par_inject = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 8 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("sb_drained", sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  // Called with rst just released; counts the not-ready cycles of the init engine.
  task automatic wait_init();
    int n;
    n = 0;
    while (!req_ready && n < 2000) begin
      if (init_busy !== 1'b1) begin
        chk("init_busy_during_init", init_busy, 1'b1);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("init_cycles", n, 32'd1024);
    chk("init_busy_after", init_busy, 1'b0);
    chk("req_ready_after", req_ready, 1'b1);
  endtask

  function automatic vec_t rd(input logic [11:0] a, input logic [3:0] d);
    return '{1'b0, a, 4'h0, 1'b0, d, 1'b0};
  endfunction

  function automatic vec_t wr(input logic [11:0] a, input logic [3:0] d, input logic inj);
    return '{1'b1, a, d, inj, 4'h0, 1'b0};
  endfunction

  initial begin
    int   rv0;
    logic exp_pe;

    vecs.push_back(rd(12'h000, 4'h0));
    vecs.push_back(rd(12'h3FF, 4'h0));
    vecs.push_back(rd(12'h400, 4'h0));
    vecs.push_back(rd(12'hFFF, 4'h0));
    vecs.push_back(wr(12'h3FF, 4'hA, 1'b0));
    vecs.push_back(wr(12'h400, 4'hB, 1'b0));
    vecs.push_back(wr(12'h800, 4'hC, 1'b0));
    vecs.push_back(wr(12'hC00, 4'hD, 1'b0));
    vecs.push_back(rd(12'h3FF, 4'hA));
    vecs.push_back(rd(12'h400, 4'hB));
    vecs.push_back(rd(12'h800, 4'hC));
    vecs.push_back(rd(12'hC00, 4'hD));
    vecs.push_back(rd(12'h3FE, 4'h0));
    vecs.push_back(rd(12'h401, 4'h0));
    vecs.push_back(rd(12'h400, 4'hB));
    vecs.push_back(rd(12'hC00, 4'hD));
    vecs.push_back(rd(12'h3FF, 4'hA));

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_init_busy", init_busy, 1'b1);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 4'h0);
    chk("rst_rd_perr", rd_perr, 1'b0);
    rst = 1'b0;
    wait_init();

    // Table: init contents, bank decode, neighbours, back-to-back reads
    foreach (vecs[i]) issue(vecs[i]);
    drain();

    // Write at N, read at N+1: new data, pulse exactly at N+3
    issue(wr(12'h123, 4'h5, 1'b0));
    issue(rd(12'h123, 4'h5));
    drain();

    // Parity hook
`ifdef BANKED_RAM_PARITY_EN
    exp_pe = 1'b1;
`else
    exp_pe = 1'b0;
`endif
    issue(wr(12'h010, 4'h7, 1'b1));
    issue('{1'b0, 12'h010, 4'h0, 1'b0, 4'h7, exp_pe});
    issue(wr(12'h010, 4'h7, 1'b0));
    issue(rd(12'h010, 4'h7));
    drain();

    // Reset with reads in flight: no pulse afterwards, memory re-zeroed
    rv0        = rv_cnt;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 12'h3FF;
    @(posedge clk); #1;
    req_addr   = 12'h400;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    req_valid  = 1'b0;
    chk("rst_mid_rd_valid", rd_valid, 1'b0);
    wait_init();
    chk("rst_mid_no_pulse", rv_cnt, rv0);
    issue(rd(12'h3FF, 4'h0));
    issue(rd(12'hC00, 4'h0));
    drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
